muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, operand/result width (even, >= 8).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(XLEN)+1, iteration counter width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: in_valid  input  1  request present.
REQ-007 Port: in_ready  output  1  block accepts request this cycle.
REQ-008 Port: funct3  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 Port: op1  input  XLEN  rs1 value / dividend.
REQ-010 Port: op2  input  XLEN  rs2 value / divisor.
REQ-011 Port: kill  input  1  abort in-flight operation (pipeline flush).
REQ-012 Port: out_valid  output  1  result present.
REQ-013 Port: out_ready  input  1  consumer accepts result.
REQ-014 Port: result  output  XLEN  operation result.

Function
REQ-015 States SHALL be IDLE, MUL, DIV, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 Accept on in_valid && in_ready: latch funct3, operand magnitudes and result-sign flags; go to MUL (funct3<4) or DIV (funct3>=4), counter=0.
REQ-017 Signedness: MUL/MULH/DIV/REM both signed; MULHSU op1 signed, op2 unsigned; MULHU/DIVU/REMU both unsigned.
REQ-018 MUL state SHALL perform one radix-2 shift-add step per cycle on magnitudes into a 2*XLEN accumulator; after XLEN steps go to DONE.
REQ-019 DIV state SHALL perform one restoring-division step per cycle on magnitudes; after XLEN steps go to DONE.
REQ-020 Normal latency: out_valid SHALL assert exactly XLEN+1 cycles after the accept edge.
REQ-021 Product sign fix: negate the 2*XLEN product iff result-sign flag set; MUL returns bits [XLEN-1:0], MULH/MULHSU/MULHU bits [2*XLEN-1:XLEN].
REQ-022 Quotient negated iff operand signs differ (signed ops); remainder takes dividend sign.
REQ-023 Divide by zero: skip DIV iterations, DONE next cycle; quotient = all ones, remainder = op1.
REQ-024 Signed overflow (op1 = most-negative, op2 = -1, DIV/REM): DONE next cycle; quotient = op1, remainder = 0.
REQ-025 DONE: out_valid=1, result stable; on out_ready go to IDLE (in_ready=1 the following cycle, no same-cycle re-accept).
REQ-026 kill in MUL, DIV or DONE SHALL return to IDLE next cycle with out_valid=0; kill in IDLE has no effect and does not block a same-cycle accept.
REQ-027 Inputs SHALL be ignored outside IDLE; op1/op2 may change after the accept.

Reset
REQ-028 rst SHALL force IDLE, counter=0, out_valid=0, result=0; in_ready=1 the cycle after rst deasserts.
REQ-029 rst mid-operation SHALL discard the operation with no out_valid pulse; rst has priority over kill and accept.

Structure
REQ-030 Package muldiv_pkg SHALL hold the funct3 encodings and the state enum type.
REQ-031 No sub-module is required; the shift-add and restoring-divide datapaths share the single accumulator/counter.

Verification
REQ-032 MULH, XLEN=32: op1=0x80000000, op2=0x80000000 -> result 0x40000000 at accept+33 cycles; MUL same operands -> 0x00000000.
REQ-033 DIV: op1=-7, op2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU op1=0xFFFFFFFF, op2=2 -> 0x7FFFFFFF.
REQ-034 DIVU op2=0, op1=5 -> 0xFFFFFFFF; REMU -> 5; DIV op1=0x80000000, op2=0xFFFFFFFF -> 0x80000000 at accept+2.
REQ-035 out_ready held 0 for 10 cycles in DONE -> result and out_valid stable; in_ready=0 throughout.
REQ-036 kill at accept+5 during DIV -> IDLE next cycle, no out_valid; a new MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-037 rst asserted at accept+10 -> out_valid=0, in_ready=1 after release; random constrained ops checked against a reference model.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 opcodes,
// FSM state type and operand signedness decode.
package muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_DONE
   } state_t;

   function automatic logic op1_signed(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
             (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic op2_signed(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) ||
             (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake bundle between a pipeline and muldiv_unit.
interface muldiv_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            kill;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;

   modport master (
      output in_valid, funct3, op1, op2, kill, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, funct3, op1, op2, kill, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on operand magnitudes sharing one 2*XLEN accumulator and counter.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  bus
);

   state_t              r_state;
   state_t              w_next;
   logic [2:0]          r_funct3;
   logic [XLEN-1:0]     r_opb;
   logic [2*XLEN-1:0]   r_acc;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_neg;
   logic                r_rem_neg;
   logic                r_skip;
   logic [XLEN-1:0]     r_result;

   logic                w_s1, w_s2, w_div0, w_ovf, w_last;
   logic [XLEN-1:0]     w_mag1, w_mag2, w_quo, w_rem, w_mul_res, w_div_res;
   logic [XLEN:0]       w_mul_sum, w_div_sub;
   logic [2*XLEN-1:0]   w_prod;

   assign w_s1   = op1_signed(bus.funct3) & bus.op1[XLEN-1];
   assign w_s2   = op2_signed(bus.funct3) & bus.op2[XLEN-1];
   assign w_mag1 = w_s1 ? -bus.op1 : bus.op1;
   assign w_mag2 = w_s2 ? -bus.op2 : bus.op2;
   assign w_div0 = (bus.op2 == '0);
   assign w_ovf  = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                   (bus.op1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op2 == '1);
   assign w_last = (r_cnt == CNT_W'(XLEN));

   // Upper accumulator half is the partial product / partial remainder.
   assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
   assign w_div_sub = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opb};

   assign w_prod    = r_neg ? -r_acc : r_acc;
   assign w_mul_res = (r_funct3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
   assign w_quo     = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
   assign w_rem     = r_rem_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
   assign w_div_res = ((r_funct3 == F3_DIV) || (r_funct3 == F3_DIVU)) ? w_quo : w_rem;

   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.result    = r_result;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (bus.in_valid) w_next = bus.funct3[2] ? ST_DIV : ST_MUL;
         ST_MUL, ST_DIV: begin
            if (bus.kill)    w_next = ST_IDLE;
            else if (w_last) w_next = ST_DONE;
         end
         ST_DONE: if (bus.kill || bus.out_ready) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_funct3  <= '0;
         r_opb     <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_neg     <= 1'b0;
         r_rem_neg <= 1'b0;
         r_skip    <= 1'b0;
         r_result  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (bus.in_valid) begin
               r_funct3  <= bus.funct3;
               r_rem_neg <= w_s1;
               if (!bus.funct3[2]) begin
                  r_opb  <= w_mag1;
                  r_acc  <= {{XLEN{1'b0}}, w_mag2};
                  r_neg  <= w_s1 ^ w_s2;
                  r_skip <= 1'b0;
                  r_cnt  <= '0;
               end else begin
                  // Special cases preload final magnitudes and run a single idle step.
                  r_opb  <= w_mag2;
                  r_acc  <= w_div0 ? {w_mag1, {XLEN{1'b1}}} : {{XLEN{1'b0}}, w_mag1};
                  r_neg  <= (w_s1 ^ w_s2) & ~w_div0;
                  r_skip <= w_div0 | w_ovf;
                  r_cnt  <= (w_div0 | w_ovf) ? CNT_W'(XLEN-1) : '0;
               end
            end
            ST_MUL: begin
               if (!w_last) begin
                  r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
                  r_cnt <= r_cnt + CNT_W'(1);
               end else begin
                  r_result <= w_mul_res;
               end
            end
            ST_DIV: begin
               if (!w_last) begin
                  if (!r_skip) begin
                     if (!w_div_sub[XLEN])
                        r_acc <= {w_div_sub[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
                     else
                        r_acc <= {r_acc[2*XLEN-2:0], 1'b0};
                  end
                  r_cnt <= r_cnt + CNT_W'(1);
               end else begin
                  r_result <= w_div_res;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
